// File: rtl/mem_wb_stage_pkg.sv
// Shared LC-3b types for the memory/writeback slice.
//   word_t     : 16-bit datapath word
//   mem_op_t   : memory operation carried with each instruction
//   WB_ALU..WB_AUX : writeback mux8 select codes (inputs a..e)
//   is_load / is_store : operation class helpers
package lc3b_types;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LDW  = 3'd1,
        MEM_LDB  = 3'd2,
        MEM_STW  = 3'd3,
        MEM_STB  = 3'd4
    } mem_op_t;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MDR = 3'd1;
    localparam logic [2:0] WB_PC  = 3'd2;
    localparam logic [2:0] WB_IMM = 3'd3;
    localparam logic [2:0] WB_AUX = 3'd4;

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LDW) || (op == MEM_LDB);
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_STW) || (op == MEM_STB);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus.
//   dmem_read/dmem_write : request strobes, held until dmem_resp
//   dmem_address         : word-aligned address
//   dmem_wdata           : store data
//   dmem_byte_enable     : lane mask
//   dmem_rdata           : read data, valid with dmem_resp
//   dmem_resp            : access complete
// master = pipeline stage, slave = memory.
interface mem_wb_stage_if #(parameter int WIDTH = 16);
    logic             dmem_read;
    logic             dmem_write;
    logic [WIDTH-1:0] dmem_address;
    logic [WIDTH-1:0] dmem_wdata;
    logic [1:0]       dmem_byte_enable;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_wb_stage_align.sv
// byte_lane_align: combinational byte-lane handling for the memory stage.
//   op, lane_hi : operation and address bit 0 selecting the byte lane
//   store_data  : store source; STB replicates [7:0] onto both lanes
//   rdata       : memory read data; LDB zero-extends the selected lane
//   wdata, byte_enable, load_data : aligned results
module byte_lane_align
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  mem_op_t          op,
    input  logic             lane_hi,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] wdata,
    output logic [1:0]       byte_enable,
    output logic [WIDTH-1:0] load_data
);

    always_comb begin
        wdata       = store_data;
        byte_enable = 2'b11;
        load_data   = rdata;
        if (op == MEM_LDB || op == MEM_STB) begin
            byte_enable = lane_hi ? 2'b10 : 2'b01;
        end
        if (op == MEM_STB) begin
            wdata = {(WIDTH/8){store_data[7:0]}};
        end
        if (op == MEM_LDB) begin
            load_data = {{(WIDTH-8){1'b0}}, (lane_hi ? rdata[15:8] : rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: LC-3b memory-access stage plus MEM/WB pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   ex_*            : instruction offered by the execute stage
//   stall_upstream  : high while a data access is outstanding
//   dmem            : data-memory bus (master side)
//   wb_*            : registered writeback controls and mux8 inputs a..e
//
//   state     | meaning
//   ST_IDLE   | no access pending; accepts ex_* offers
//   ST_ACCESS | memory request held on dmem until dmem_resp
module mem_wb_stage
    import lc3b_types::*;
#(
    parameter int WIDTH   = 16,
    parameter int REG_IDX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_flush,
    input  mem_op_t            ex_op,
    input  logic [WIDTH-1:0]   ex_addr,
    input  logic [WIDTH-1:0]   ex_store_data,
    input  logic [WIDTH-1:0]   ex_alu,
    input  logic [WIDTH-1:0]   ex_pc_next,
    input  logic [WIDTH-1:0]   ex_imm,
    input  logic [WIDTH-1:0]   ex_aux,
    input  logic [2:0]         ex_wb_sel,
    input  logic               ex_regwrite,
    input  logic [REG_IDX-1:0] ex_dest,
    output logic               stall_upstream,
    mem_wb_stage_if.master     dmem,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic [REG_IDX-1:0] wb_dest,
    output logic [2:0]         wb_sel,
    output logic [WIDTH-1:0]   wb_alu,
    output logic [WIDTH-1:0]   wb_mdr,
    output logic [WIDTH-1:0]   wb_pc,
    output logic [WIDTH-1:0]   wb_imm,
    output logic [WIDTH-1:0]   wb_aux
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t           state;
    mem_op_t          pend_op;
    logic             pend_lane;
    logic             accept;
    mem_op_t          al_op;
    logic             al_lane;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_load;
    logic [1:0]       al_be;

    assign stall_upstream = (state == ST_ACCESS);
    assign accept         = ex_valid & ~stall_upstream & ~ex_flush;

    // One aligner serves both phases: the offered op when building the
    // request, the pending op when extracting the response.
    assign al_op   = (state == ST_ACCESS) ? pend_op   : ex_op;
    assign al_lane = (state == ST_ACCESS) ? pend_lane : ex_addr[0];

    byte_lane_align #(.WIDTH(WIDTH)) u_align (
        .op          (al_op),
        .lane_hi     (al_lane),
        .store_data  (ex_store_data),
        .rdata       (dmem.dmem_rdata),
        .wdata       (al_wdata),
        .byte_enable (al_be),
        .load_data   (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            pend_op               <= MEM_NONE;
            pend_lane             <= 1'b0;
            dmem.dmem_read        <= 1'b0;
            dmem.dmem_write       <= 1'b0;
            dmem.dmem_address     <= '0;
            dmem.dmem_wdata       <= '0;
            dmem.dmem_byte_enable <= 2'b00;
            wb_valid              <= 1'b0;
            wb_regwrite           <= 1'b0;
            wb_dest               <= '0;
            wb_sel                <= 3'd0;
            wb_alu                <= '0;
            wb_mdr                <= '0;
            wb_pc                 <= '0;
            wb_imm                <= '0;
            wb_aux                <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wb_alu      <= ex_alu;
                        wb_pc       <= ex_pc_next;
                        wb_imm      <= ex_imm;
                        wb_aux      <= ex_aux;
                        wb_mdr      <= '0;
                        wb_sel      <= ex_wb_sel;
                        wb_dest     <= ex_dest;
                        wb_regwrite <= ex_regwrite & ~is_store(ex_op);
                        if (ex_op == MEM_NONE) begin
                            wb_valid <= 1'b1;
                        end else begin
                            state                 <= ST_ACCESS;
                            pend_op               <= ex_op;
                            pend_lane             <= ex_addr[0];
                            dmem.dmem_read        <= is_load(ex_op);
                            dmem.dmem_write       <= is_store(ex_op);
                            dmem.dmem_address     <= {ex_addr[WIDTH-1:1], 1'b0};
                            dmem.dmem_wdata       <= al_wdata;
                            dmem.dmem_byte_enable <= al_be;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem.dmem_resp) begin
                        state           <= ST_IDLE;
                        dmem.dmem_read  <= 1'b0;
                        dmem.dmem_write <= 1'b0;
                        wb_valid        <= 1'b1;
                        if (is_load(pend_op)) begin
                            wb_mdr <= al_load;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_flush, ex_regwrite;
    mem_op_t     ex_op;
    logic [15:0] ex_addr, ex_store_data, ex_alu, ex_pc_next, ex_imm, ex_aux;
    logic [2:0]  ex_wb_sel;
    logic [2:0]  ex_dest;
    logic        stall_upstream;
    logic        wb_valid, wb_regwrite;
    logic [2:0]  wb_dest, wb_sel;
    logic [15:0] wb_alu, wb_mdr, wb_pc, wb_imm, wb_aux;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage_if #(.WIDTH(16)) dmem ();

    mem_wb_stage #(.WIDTH(16), .REG_IDX(3)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_alu(ex_alu),
        .ex_pc_next(ex_pc_next), .ex_imm(ex_imm), .ex_aux(ex_aux),
        .ex_wb_sel(ex_wb_sel), .ex_regwrite(ex_regwrite), .ex_dest(ex_dest),
        .stall_upstream(stall_upstream), .dmem(dmem.master),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_mdr(wb_mdr), .wb_pc(wb_pc),
        .wb_imm(wb_imm), .wb_aux(wb_aux)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_flush = 1'b0; ex_op = MEM_NONE;
        ex_addr = '0; ex_store_data = '0; ex_alu = '0; ex_pc_next = '0;
        ex_imm = '0; ex_aux = '0; ex_wb_sel = 3'd0; ex_regwrite = 1'b0; ex_dest = 3'd0;
    endtask

    // Offer one memory op, let memory respond after lat idle cycles, check the
    // request, the stall length and the retired writeback fields.
    task automatic run_mem(input string tag, input mem_op_t op, input logic [15:0] addr,
                           input logic [15:0] sd, input logic [15:0] rd, input int lat,
                           input logic [15:0] e_addr, input logic [1:0] e_be,
                           input logic [15:0] e_wdata, input logic e_rd, input logic e_wr,
                           input logic [15:0] e_mdr, input logic e_rw);
        int stalls;
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_store_data = sd;
        ex_alu = 16'h7777; ex_wb_sel = WB_MDR; ex_regwrite = 1'b1; ex_dest = 3'd5;
        step();
        idle_inputs();
        chk({tag, " rd strobe"}, dmem.dmem_read, e_rd);
        chk({tag, " wr strobe"}, dmem.dmem_write, e_wr);
        chk({tag, " address"}, dmem.dmem_address, e_addr);
        chk({tag, " byte_en"}, dmem.dmem_byte_enable, e_be);
        if (e_wr) chk({tag, " wdata"}, dmem.dmem_wdata, e_wdata);
        chk({tag, " no wb yet"}, wb_valid, 1'b0);
        stalls = 0;
        for (int i = 0; i < lat; i++) begin
            if (stall_upstream) stalls++;
            step();
        end
        chk({tag, " strobe held"}, dmem.dmem_read | dmem.dmem_write, 1'b1);
        chk({tag, " addr held"}, dmem.dmem_address, e_addr);
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = rd;
        if (stall_upstream) stalls++;
        step();
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = '0;
        chk({tag, " stall cycles"}, 16'(stalls), 16'(lat + 1));
        chk({tag, " wb_valid"}, wb_valid, 1'b1);
        chk({tag, " strobes drop"}, dmem.dmem_read | dmem.dmem_write, 1'b0);
        chk({tag, " stall drop"}, stall_upstream, 1'b0);
        chk({tag, " wb_mdr"}, wb_mdr, e_mdr);
        chk({tag, " wb_regwrite"}, wb_regwrite, e_rw);
        chk({tag, " wb_dest"}, wb_dest, 3'd5);
        chk({tag, " wb_alu"}, wb_alu, 16'h7777);
        step();
        chk({tag, " wb pulse"}, wb_valid, 1'b0);
    endtask

    initial begin
        idle_inputs();
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = '0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst wb_valid", wb_valid, 1'b0);
        chk("rst stall", stall_upstream, 1'b0);
        chk("rst strobes", dmem.dmem_read | dmem.dmem_write, 1'b0);
        chk("rst wb_alu", wb_alu, 16'h0000);
        chk("rst byte_en", dmem.dmem_byte_enable, 2'b00);

        // ALU op, 1-cycle latency
        ex_valid = 1'b1; ex_op = MEM_NONE; ex_alu = 16'h1234; ex_wb_sel = WB_ALU;
        ex_regwrite = 1'b1; ex_dest = 3'd2; ex_pc_next = 16'h3002;
        step();
        idle_inputs();
        chk("alu wb_valid", wb_valid, 1'b1);
        chk("alu wb_alu", wb_alu, 16'h1234);
        chk("alu wb_pc", wb_pc, 16'h3002);
        chk("alu wb_sel", wb_sel, WB_ALU);
        chk("alu no strobe", dmem.dmem_read | dmem.dmem_write, 1'b0);
        chk("alu stall", stall_upstream, 1'b0);
        step();
        chk("alu pulse", wb_valid, 1'b0);

        run_mem("ldw", MEM_LDW, 16'h0041, 16'h0000, 16'hBEEF, 3,
                16'h0040, 2'b11, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1);
        run_mem("ldb_hi", MEM_LDB, 16'h0101, 16'h0000, 16'hA55A, 1,
                16'h0100, 2'b10, 16'h0000, 1'b1, 1'b0, 16'h00A5, 1'b1);
        run_mem("ldb_lo", MEM_LDB, 16'h0100, 16'h0000, 16'hA55A, 0,
                16'h0100, 2'b01, 16'h0000, 1'b1, 1'b0, 16'h005A, 1'b1);
        run_mem("stb", MEM_STB, 16'h0200, 16'h00C3, 16'hFFFF, 2,
                16'h0200, 2'b01, 16'hC3C3, 1'b0, 1'b1, 16'h0000, 1'b0);
        run_mem("stw", MEM_STW, 16'h0303, 16'h9876, 16'hFFFF, 1,
                16'h0302, 2'b11, 16'h9876, 1'b0, 1'b1, 16'h0000, 1'b0);

        // Back-to-back: LDW then an ALU op held upstream during the access
        ex_valid = 1'b1; ex_op = MEM_LDW; ex_addr = 16'h0010; ex_alu = 16'h0000;
        ex_wb_sel = WB_MDR; ex_regwrite = 1'b1; ex_dest = 3'd1;
        step();
        ex_op = MEM_NONE; ex_alu = 16'h5555; ex_wb_sel = WB_ALU; ex_dest = 3'd3;
        chk("b2b stall", stall_upstream, 1'b1);
        step();
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'h1111;
        chk("b2b alu held", wb_valid, 1'b0);
        step();
        dmem.dmem_resp = 1'b0;
        chk("b2b ld retire", wb_valid, 1'b1);
        chk("b2b ld mdr", wb_mdr, 16'h1111);
        chk("b2b ld alu", wb_alu, 16'h0000);
        step();
        idle_inputs();
        chk("b2b alu retire", wb_valid, 1'b1);
        chk("b2b alu value", wb_alu, 16'h5555);
        chk("b2b alu dest", wb_dest, 3'd3);
        step();
        chk("b2b quiet", wb_valid, 1'b0);

        // Reset during ACCESS, then a late response
        ex_valid = 1'b1; ex_op = MEM_LDW; ex_addr = 16'h0020;
        step();
        idle_inputs();
        chk("rstacc strobe up", dmem.dmem_read, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstacc idle", stall_upstream, 1'b0);
        chk("rstacc strobe low", dmem.dmem_read, 1'b0);
        chk("rstacc wb_valid", wb_valid, 1'b0);
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'hDEAD;
        step();
        dmem.dmem_resp = 1'b0;
        chk("late resp wb_valid", wb_valid, 1'b0);
        chk("late resp mdr", wb_mdr, 16'h0000);

        // Flushed STW offer
        ex_valid = 1'b1; ex_flush = 1'b1; ex_op = MEM_STW; ex_addr = 16'h0400;
        ex_store_data = 16'h4242;
        step();
        idle_inputs();
        chk("flush no write", dmem.dmem_write, 1'b0);
        chk("flush no stall", stall_upstream, 1'b0);
        chk("flush wb_valid", wb_valid, 1'b0);

        // Stray response while idle
        dmem.dmem_resp = 1'b1;
        step();
        dmem.dmem_resp = 1'b0;
        chk("idle resp wb_valid", wb_valid, 1'b0);
        chk("idle resp stall", stall_upstream, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
